// File: rtl/bru_pipe.sv
// Branch resolution unit: resolves conditional branches and JAL/JALR, flags mispredictions,
// and carries each op down a STAGES-deep valid/ready pipe that honours the EBR branch bus.
package bru_pkg;
    localparam int XLEN   = 32;
    localparam int MASK_W = 4;
    localparam int TAG_W  = $clog2(MASK_W);

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    localparam logic TGT_PC  = 1'b0;
    localparam logic TGT_RS1 = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      op;
        logic [XLEN-1:0] imm;
        logic            target_mux;
    } ctrl_t;

    typedef struct packed {
        logic [MASK_W-1:0] branch_mask;
    } meta_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] psr1_data;
        meta_t           meta;
    } issue_stage_t;

    typedef struct packed {
        logic [XLEN-1:0] target_addr;
        logic [XLEN-1:0] return_addr;
        logic            br_en;
    } bru_result_t;

    typedef struct packed {
        logic             broadcast;
        logic [TAG_W-1:0] tag;
        logic             clean;
        logic             kill;
    } brif_t;
endpackage

module bru_pipe
    import bru_pkg::*;
#(
    parameter int STAGES = 2,
    // Struct widths come from bru_pkg; these track the package values.
    parameter int XLEN   = bru_pkg::XLEN,
    parameter int MASK_W = bru_pkg::MASK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  brif_t             brif_i,
    input  issue_stage_t      istage_i,
    input  logic [XLEN-1:0]   bru_a_i,
    input  logic [XLEN-1:0]   bru_b_i,
    input  logic              is_jump_i,
    input  logic              pred_taken_i,
    input  logic [XLEN-1:0]   pred_target_i,
    input  logic              ivalid_i,
    output logic              iready_o,
    output issue_stage_t      ostage_o,
    output bru_result_t       oresult_o,
    output logic              omispredict_o,
    output logic [XLEN-1:0]   ofix_pc_o,
    output logic              ovalid_o,
    input  logic              oready_i
);
    typedef struct packed {
        issue_stage_t st;
        bru_result_t  res;
        logic         mispredict;
    } entry_t;

    logic [STAGES-1:0] valid_q, valid_d;
    entry_t            entry_q [STAGES];
    entry_t            entry_d [STAGES];
    logic [STAGES:0]   ready;
    logic [STAGES-1:0] src_v;
    entry_t            src_e   [STAGES];

    logic [XLEN-1:0] base, target;
    logic            br_en, eq, lt_s, lt_u;
    entry_t          in_entry;

    always_comb begin
        base   = (istage_i.ctrl.target_mux == TGT_RS1) ? istage_i.psr1_data : istage_i.ctrl.pc;
        target = base + istage_i.ctrl.imm;
        if (is_jump_i && istage_i.ctrl.target_mux == TGT_RS1) begin
            target[0] = 1'b0;
        end
        eq   = (bru_a_i == bru_b_i);
        lt_s = ($signed(bru_a_i) < $signed(bru_b_i));
        lt_u = (bru_a_i < bru_b_i);
        case (istage_i.ctrl.op)
            OP_BEQ:  br_en = eq;
            OP_BNE:  br_en = !eq;
            OP_BLT:  br_en = lt_s;
            OP_BGE:  br_en = !lt_s;
            OP_BLTU: br_en = lt_u;
            OP_BGEU: br_en = !lt_u;
            default: br_en = 1'b0;
        endcase
        if (is_jump_i) begin
            br_en = 1'b1;
        end
        in_entry                 = '0;
        in_entry.st              = istage_i;
        in_entry.res.target_addr = target;
        in_entry.res.return_addr = istage_i.ctrl.pc + XLEN'(4);
        in_entry.res.br_en       = br_en;
        in_entry.mispredict      = (br_en != pred_taken_i) ||
                                   (br_en && pred_taken_i && target != pred_target_i);
    end

    // A stage may load whenever it is empty or the stage below is draining.
    always_comb begin
        ready         = '0;
        ready[STAGES] = oready_i;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ready[i] = !valid_q[i] || ready[i+1];
        end
    end

    always_comb begin
        src_v[0] = ivalid_i;
        src_e[0] = in_entry;
        for (int i = 1; i < STAGES; i++) begin
            src_v[i] = valid_q[i-1];
            src_e[i] = entry_q[i-1];
        end
    end

    // Bus is applied to whatever the stage holds next cycle, so freshly captured ops are covered too.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i] = ready[i] ? src_v[i] : valid_q[i];
            entry_d[i] = ready[i] ? src_e[i] : entry_q[i];
            if (brif_i.broadcast && entry_d[i].st.meta.branch_mask[brif_i.tag]) begin
                if (brif_i.clean) begin
                    entry_d[i].st.meta.branch_mask[brif_i.tag] = 1'b0;
                end else if (brif_i.kill) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign iready_o      = ready[0];
    assign ovalid_o      = valid_q[STAGES-1];
    assign ostage_o      = entry_q[STAGES-1].st;
    assign oresult_o     = entry_q[STAGES-1].res;
    assign omispredict_o = entry_q[STAGES-1].mispredict;
    assign ofix_pc_o     = entry_q[STAGES-1].res.br_en ? entry_q[STAGES-1].res.target_addr
                                                       : entry_q[STAGES-1].res.return_addr;
endmodule
